// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: front end between the raw I2C pads and the I2C slave.
// Synchronizes and deglitches SCL/SDA, flags START/STOP and bus-busy, and
// runs a stuck-SDA watchdog that pulses a recovery reset into the slave.
//   clk, rst_n          board clock, async active-low reset
//   scl_raw, sda_raw    asynchronous pad inputs
//   scl_filt, sda_filt  synchronized + deglitched lines
//   start_det/stop_det  one-cycle event pulses
//   bus_busy            high between START and STOP
//   stuck_sda/scl       timeout status
//   i2c_rst_n           registered active-low recovery reset to the slave
//   rec_count           saturating count of recovery events

// Per-line synchronizer + stability filter.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (sync[SYNC_STAGES-1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_CYCLES - 1)) begin
        // FILT_CYCLES consecutive mismatching cycles: accept the new level
        filt <= sync[SYNC_STAGES-1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module i2c_bus_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int FILT_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES   = 32000,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_raw,
  input  logic       sda_raw,
  output logic       scl_filt,
  output logic       sda_filt,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       stuck_sda,
  output logic       stuck_scl,
  output logic       i2c_rst_n,
  output logic [7:0] rec_count
);
  localparam int NUM_LANES = 2;  // lane 0 = SCL, lane 1 = SDA
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECOVER, HOLDOFF} state_t;

  logic [NUM_LANES-1:0] raw_v, filt_v;
  logic                 scl_d, sda_d;
  logic [TW-1:0]        sda_low_cnt, scl_low_cnt;
  logic [PW-1:0]        pulse_cnt;
  state_t               state;
  logic                 rec_entry;

  assign raw_v    = {sda_raw, scl_raw};
  assign scl_filt = filt_v[0];
  assign sda_filt = filt_v[1];

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt [NUM_LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw_v),
    .filt (filt_v)
  );

  assign rec_entry = (state == IDLE) && (sda_low_cnt == TW'(TIMEOUT_CYCLES));

  // Edge detect; SCL must be high on both sides, so a simultaneous SCL/SDA
  // change never qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      scl_d     <= scl_filt;
      sda_d     <= sda_filt;
      start_det <=  sda_d & ~sda_filt & scl_d & scl_filt;
      stop_det  <= ~sda_d &  sda_filt & scl_d & scl_filt;
      if (stop_det || rec_entry) bus_busy <= 1'b0;
      else if (start_det)        bus_busy <= 1'b1;
    end
  end

  // Saturating low-time counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_low_cnt <= '0;
      scl_low_cnt <= '0;
      stuck_scl   <= 1'b0;
    end else begin
      if (sda_filt)                                 sda_low_cnt <= '0;
      else if (sda_low_cnt != TW'(TIMEOUT_CYCLES)) sda_low_cnt <= sda_low_cnt + 1'b1;
      if (scl_filt)                                 scl_low_cnt <= '0;
      else if (scl_low_cnt != TW'(TIMEOUT_CYCLES)) scl_low_cnt <= scl_low_cnt + 1'b1;
      stuck_scl <= (scl_low_cnt == TW'(TIMEOUT_CYCLES));
    end
  end

  // Recovery FSM. HOLDOFF only exits once SDA is seen high, which also
  // clears sda_low_cnt, so a single stuck episode yields a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stuck_sda <= 1'b0;
      i2c_rst_n <= 1'b1;
      pulse_cnt <= '0;
      rec_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rec_entry) begin
            state     <= RECOVER;
            stuck_sda <= 1'b1;
            i2c_rst_n <= 1'b0;
            pulse_cnt <= '0;
            if (rec_count != 8'hFF) rec_count <= rec_count + 1'b1;
          end
        end
        RECOVER: begin
          if (pulse_cnt == PW'(RST_PULSE_CYCLES - 1)) begin
            state     <= HOLDOFF;
            i2c_rst_n <= 1'b1;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (sda_filt) begin
            state     <= IDLE;
            stuck_sda <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          stuck_sda <= 1'b0;
          i2c_rst_n <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner (short timeout so all
// scenarios, including 300 stuck episodes, fit in a few tens of k cycles).
module tb_i2c_bus_conditioner;
  localparam int TO = 40;
  localparam int PL = 16;

  logic       clk = 1'b0;
  logic       rst_n, scl_raw, sda_raw;
  logic       scl_filt, sda_filt, start_det, stop_det, bus_busy;
  logic       stuck_sda, stuck_scl, i2c_rst_n;
  logic [7:0] rec_count;

  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_rlow = 0, n_rfall = 0;
  logic rst_prev = 1'b1;

  i2c_bus_conditioner #(
    .SYNC_STAGES(2), .FILT_CYCLES(4), .TIMEOUT_CYCLES(TO), .RST_PULSE_CYCLES(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_raw(scl_raw), .sda_raw(sda_raw),
    .scl_filt(scl_filt), .sda_filt(sda_filt), .start_det(start_det),
    .stop_det(stop_det), .bus_busy(bus_busy), .stuck_sda(stuck_sda),
    .stuck_scl(stuck_scl), .i2c_rst_n(i2c_rst_n), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  // Event monitors, sampled on the inactive edge
  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (!i2c_rst_n) n_rlow++;
    if (rst_prev && !i2c_rst_n) n_rfall++;
    rst_prev = i2c_rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int s0, p0, l0, f0, n, m;
    logic to_hit;
    rst_n = 1'b0; scl_raw = 1'b1; sda_raw = 1'b1;

    // 1: reset state and idle bus
    #12;
    chk("rst_scl_filt", scl_filt, 1);
    chk("rst_sda_filt", sda_filt, 1);
    chk("rst_i2c_rst_n", i2c_rst_n, 1);
    chk("rst_rec_count", rec_count, 0);
    chk("rst_busy", bus_busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    s0 = n_start; p0 = n_stop;
    step(100);
    chk("idle_scl", scl_filt, 1);
    chk("idle_sda", sda_filt, 1);
    chk("idle_pulses", (n_start - s0) + (n_stop - p0), 0);
    chk("idle_busy", bus_busy, 0);
    chk("idle_stuck", {stuck_sda, stuck_scl}, 0);

    // 2: START, SCL toggling, STOP
    s0 = n_start; p0 = n_stop;
    sda_raw = 1'b0; n = 0;
    while (sda_filt && n < 20) begin step(1); n++; end
    chk("lat_sda_fall", n, 6);
    step(3);
    chk("start_cnt", n_start - s0, 1);
    chk("busy_after_start", bus_busy, 1);
    scl_raw = 1'b0; step(8);
    scl_raw = 1'b1; step(8);
    chk("no_evt_on_scl", (n_start - s0) + (n_stop - p0), 1);
    sda_raw = 1'b1; n = 0;
    while (!sda_filt && n < 20) begin step(1); n++; end
    chk("lat_sda_rise", n, 6);
    step(3);
    chk("stop_cnt", n_stop - p0, 1);
    chk("busy_after_stop", bus_busy, 0);

    // 3: glitch rejection, then a pulse long enough to pass
    s0 = n_start; p0 = n_stop;
    sda_raw = 1'b0; step(3); sda_raw = 1'b1; step(15);
    chk("glitch_sda", sda_filt, 1);
    chk("glitch_no_start", n_start - s0, 0);
    sda_raw = 1'b0; step(6); sda_raw = 1'b1; step(15);
    chk("pulse_start", n_start - s0, 1);
    chk("pulse_stop", n_stop - p0, 1);
    chk("pulse_busy", bus_busy, 0);

    // 4: stuck SDA -> one recovery pulse
    l0 = n_rlow; f0 = n_rfall;
    sda_raw = 1'b0; n = 0;
    while (sda_filt && n < 20) begin step(1); n++; end
    step(5);
    chk("stuck_busy_set", bus_busy, 1);
    m = 5;
    while (!stuck_sda && m < 100) begin step(1); m++; end
    chk("stuck_latency", m, TO + 1);
    chk("stuck_rst_low", i2c_rst_n, 0);
    chk("stuck_busy_clr", bus_busy, 0);
    chk("stuck_rec1", rec_count, 1);
    step(40);
    chk("holdoff_stuck", stuck_sda, 1);
    chk("holdoff_rst_hi", i2c_rst_n, 1);
    sda_raw = 1'b1; step(12);
    chk("stuck_cleared", stuck_sda, 0);
    chk("pulse_len", n_rlow - l0, PL);
    chk("pulse_once", n_rfall - f0, 1);
    chk("rec_after", rec_count, 1);

    // 5: stuck SCL is status only
    l0 = n_rlow;
    scl_raw = 1'b0; step(60);
    chk("stuck_scl_set", stuck_scl, 1);
    chk("scl_no_rst", n_rlow - l0, 0);
    chk("scl_rec", rec_count, 1);
    chk("scl_no_stuck_sda", stuck_sda, 0);
    scl_raw = 1'b1; step(10);
    chk("stuck_scl_clr", stuck_scl, 0);

    // 6a: reset in the middle of a recovery pulse
    sda_raw = 1'b0; n = 0;
    while (i2c_rst_n && n < 100) begin step(1); n++; end
    chk("rec2_reached", n < 100, 1);
    step(3);
    rst_n = 1'b0; #1;
    chk("async_rst_n", i2c_rst_n, 1);
    chk("async_stuck", stuck_sda, 0);
    chk("async_rec", rec_count, 0);
    sda_raw = 1'b1; step(2);
    rst_n = 1'b1;
    l0 = n_rlow;
    step(60);
    chk("post_rst_idle", n_rlow - l0, 0);
    chk("post_rst_stuck", stuck_sda, 0);

    // 6b: 300 episodes, counter saturates
    f0 = n_rfall; to_hit = 1'b0;
    for (int e = 0; e < 300; e++) begin
      sda_raw = 1'b0; n = 0;
      while (!stuck_sda && n < 100) begin step(1); n++; end
      if (n >= 100) to_hit = 1'b1;
      sda_raw = 1'b1; n = 0;
      while (stuck_sda && n < 100) begin step(1); n++; end
      if (n >= 100) to_hit = 1'b1;
      step(2);
      if (e == 254) chk("rec_255", rec_count, 255);
    end
    chk("episode_timeout", to_hit, 0);
    chk("rec_sat", rec_count, 255);
    chk("sat_pulses", n_rfall - f0, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
